sc_dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-cycle CPU's data-memory/I-O space. Shares one memory-side port (address, write data, write enable, read data) between requester 0 (CPU load/store path) and requester 1 (debug/loader port), one transaction at a time. Uses round-robin grant and a fixed access/response sequence. Sits between the requesters and the data-memory/I-O wrapper, whose `addr[7]` selects I/O (1) versus RAM (0).

---
 rtl/sc_dmem_arbiter_pkg.sv | 14 +
 rtl/sc_dmem_arbiter_rr_pick2.sv | 13 +
 rtl/sc_dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_sc_dmem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and parameter defaults.
package sc_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned AddrWDefault = 32;
  localparam int unsigned IoBitDefault = 7;

endpackage

// File: rtl/sc_dmem_arbiter_rr_pick2.sv
// Two-input round-robin winner select; on a tie the port that was not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the CPU data-memory/I-O port.
// Build option: SC_ARB_IO_PROTECT_EN suppresses requester-1 writes to I/O space.
module sc_dmem_arbiter
  import sc_dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned IO_BIT = IoBitDefault
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              io_write_blocked
);

  if (IO_BIT >= ADDR_W) begin : g_bad_io_bit
    $error("IO_BIT must lie inside the address");
  end

  arb_state_e state_q;
  logic       last_q;
  logic       owner_q;

  logic              in_resp;
  logic              pick_req0;
  logic              pick_req1;
  logic              pick_valid;
  logic              pick_winner;
  logic              capture;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              wr_blocked;

  // During RESP only the other port may be captured; the owner must re-request after done.
  always_comb begin
    in_resp   = (state_q == StResp);
    pick_req0 = req0 & ~(in_resp & ~owner_q);
    pick_req1 = req1 & ~(in_resp & owner_q);
  end

  rr_pick2 u_pick (
    .req0   (pick_req0),
    .req1   (pick_req1),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    capture   = pick_valid & ((state_q == StIdle) | (state_q == StResp));
    win_we    = pick_winner ? we1    : we0;
    win_addr  = pick_winner ? addr1  : addr0;
    win_wdata = pick_winner ? wdata1 : wdata0;
  end

`ifdef SC_ARB_IO_PROTECT_EN
  logic blocked_q;

  assign wr_blocked       = pick_winner & win_we & win_addr[IO_BIT];
  assign io_write_blocked = blocked_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blocked_q <= 1'b0;
    end else if (capture && wr_blocked) begin
      blocked_q <= 1'b1;
    end
  end
`else
  assign wr_blocked       = 1'b0;
  assign io_write_blocked = 1'b0;
`endif

  // Memory-side signals are loaded at capture so they are valid for the whole ACCESS cycle;
  // mem_addr/mem_wdata double as the latched request and hold until the next capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;

      unique case (state_q)
        StIdle: begin
        end
        StAccess: begin
          // Read data is registered here so it is valid alongside done in RESP.
          state_q <= StResp;
          rdata   <= mem_dataout;
          done0   <= ~owner_q;
          done1   <= owner_q;
        end
        StResp: begin
          state_q <= StIdle;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
        end
      endcase

      if (capture) begin
        state_q   <= StAccess;
        owner_q   <= pick_winner;
        last_q    <= pick_winner;
        gnt0      <= ~pick_winner;
        gnt1      <= pick_winner;
        mem_addr  <= win_addr;
        mem_wdata <= win_wdata;
        mem_we    <= win_we & ~wr_blocked;
      end
    end
  end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Self-checking bench for sc_dmem_arbiter: per-scenario tasks with a read-data scoreboard.
module tb_sc_dmem_arbiter;

  logic        clock;
  logic        resetn;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, mem_we, io_write_blocked;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_dataout;

  int checks;
  int passed;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  sc_dmem_arbiter dut (
    .clock            (clock),
    .resetn           (resetn),
    .req0             (req0),
    .req1             (req1),
    .we0              (we0),
    .we1              (we1),
    .addr0            (addr0),
    .addr1            (addr1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .done0            (done0),
    .done1            (done1),
    .rdata            (rdata),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we),
    .mem_dataout      (mem_dataout),
    .io_write_blocked (io_write_blocked)
  );

  // Memory model: fixed pattern per address, with the documented 0x14 -> 0xDEADBEEF entry.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h14) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign mem_dataout = mem_model(mem_addr);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    resetn = 0;
    idle_inputs();
    repeat (2) @(negedge clock);
    resetn = 1;
  endtask

  task automatic test_reset;
    logic [101:0] v;
    resetn = 0;
    idle_inputs();
    repeat (2) @(negedge clock);
    v = {gnt0, gnt1, done0, done1, mem_we, io_write_blocked, rdata, mem_addr, mem_wdata};
    checks++; if (v !== '0) $display("FAIL reset_outputs: got %h expected 0", v); else passed++;
    resetn = 1;
    @(negedge clock);
    v = {gnt0, gnt1, done0, done1, mem_we, io_write_blocked, rdata, mem_addr, mem_wdata};
    checks++; if (v !== '0) $display("FAIL idle_outputs: got %h expected 0", v); else passed++;
  endtask

  task automatic test_single_read;
    logic gnt1_seen;
    logic [31:0] exp;
    gnt1_seen = 0;
    req0 = 1; we0 = 0; addr0 = 32'h14;
    q0.push_back(mem_model(addr0));
    @(negedge clock);
    gnt1_seen |= gnt1;
    checks++; if (mem_addr !== 32'h14) $display("FAIL read_addr: got %h expected 14", mem_addr);
    else passed++;
    checks++; if ({gnt0, mem_we, done0} !== 3'b100)
      $display("FAIL read_access: got %b expected 100", {gnt0, mem_we, done0}); else passed++;
    @(negedge clock);
    gnt1_seen |= gnt1;
    checks++; if (done0 !== 1'b1) $display("FAIL read_done: got %b expected 1", done0);
    else passed++;
    exp = (q0.size() != 0) ? q0.pop_front() : 'x;
    checks++; if (rdata !== exp) $display("FAIL read_rdata: got %h expected %h", rdata, exp);
    else passed++;
    req0 = 0;
    @(negedge clock);
    gnt1_seen |= gnt1;
    checks++; if ({gnt0, done0} !== 2'b00)
      $display("FAIL read_release: got %b expected 00", {gnt0, done0}); else passed++;
    checks++; if (gnt1_seen !== 1'b0) $display("FAIL read_gnt1: got %b expected 0", gnt1_seen);
    else passed++;
  endtask

  task automatic test_simultaneous;
    logic [31:0] exp;
    do_reset();
    req0 = 1; we0 = 0; addr0 = 32'h20;
    req1 = 1; we1 = 0; addr1 = 32'h24;
    q0.push_back(mem_model(addr0));
    q1.push_back(mem_model(addr1));
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (cyc == 3) begin
        checks++; if ({gnt0, gnt1, mem_addr} !== {2'b01, 32'h24})
          $display("FAIL sim_port1_access: got %b %h expected 01 24", {gnt0, gnt1}, mem_addr);
        else passed++;
      end
      if (done0) begin
        checks++; if (cyc != 2) $display("FAIL sim_done0_cycle: got %0d expected 2", cyc);
        else passed++;
        exp = (q0.size() != 0) ? q0.pop_front() : 'x;
        checks++; if (rdata !== exp) $display("FAIL sim_rdata0: got %h expected %h", rdata, exp);
        else passed++;
        req0 = 0;
      end
      if (done1) begin
        checks++; if (cyc != 4) $display("FAIL sim_done1_cycle: got %0d expected 4", cyc);
        else passed++;
        exp = (q1.size() != 0) ? q1.pop_front() : 'x;
        checks++; if (rdata !== exp) $display("FAIL sim_rdata1: got %h expected %h", rdata, exp);
        else passed++;
        req1 = 0;
      end
    end
    checks++; if (q0.size() + q1.size() != 0)
      $display("FAIL sim_pending: got %0d expected 0", q0.size() + q1.size()); else passed++;
    q0.delete(); q1.delete();
  endtask

  task automatic test_single_write;
    int nwe, ndone;
    nwe = 0; ndone = 0;
    req1 = 1; we1 = 1; addr1 = 32'h08; wdata1 = 32'h55;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (mem_we) begin
        nwe++;
        checks++; if ({mem_addr, mem_wdata} !== {32'h08, 32'h55})
          $display("FAIL wr_bus: got %h %h expected 08 55", mem_addr, mem_wdata); else passed++;
      end
      if (done1) begin
        ndone++;
        req1 = 0; we1 = 0;
      end
    end
    checks++; if (nwe != 1) $display("FAIL wr_we_cycles: got %0d expected 1", nwe); else passed++;
    checks++; if (ndone != 1) $display("FAIL wr_done: got %0d expected 1", ndone); else passed++;
  endtask

  task automatic test_io_protect;
    int nwe, ndone, exp_we;
    logic exp_blk;
`ifdef SC_ARB_IO_PROTECT_EN
    exp_we = 0; exp_blk = 1;
`else
    exp_we = 1; exp_blk = 0;
`endif
    nwe = 0; ndone = 0;
    req1 = 1; we1 = 1; addr1 = 32'h80; wdata1 = 32'hA5;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (mem_we) nwe++;
      if (done1) begin ndone++; req1 = 0; we1 = 0; end
    end
    checks++; if (nwe != exp_we) $display("FAIL io1_we: got %0d expected %0d", nwe, exp_we);
    else passed++;
    checks++; if (ndone != 1) $display("FAIL io1_done: got %0d expected 1", ndone); else passed++;
    checks++; if (io_write_blocked !== exp_blk)
      $display("FAIL io1_flag: got %b expected %b", io_write_blocked, exp_blk); else passed++;
    nwe = 0;
    req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'h3C;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clock);
      if (mem_we) nwe++;
      if (done0) begin req0 = 0; we0 = 0; end
    end
    checks++; if (nwe != 1) $display("FAIL io0_we: got %0d expected 1", nwe); else passed++;
    checks++; if (io_write_blocked !== exp_blk)
      $display("FAIL io_flag_sticky: got %b expected %b", io_write_blocked, exp_blk); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [101:0] v;
    req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'h77;
    @(negedge clock);
    checks++; if ({gnt0, mem_we} !== 2'b11)
      $display("FAIL rst_pre_access: got %b expected 11", {gnt0, mem_we}); else passed++;
    resetn = 0;
    #1;
    v = {gnt0, gnt1, done0, done1, mem_we, io_write_blocked, rdata, mem_addr, mem_wdata};
    checks++; if (v !== '0) $display("FAIL rst_async: got %h expected 0", v); else passed++;
    @(negedge clock);
    resetn = 1;
    req0 = 1; we0 = 0; addr0 = 32'h40;
    req1 = 1; we1 = 0; addr1 = 32'h44;
    @(negedge clock);
    checks++; if ({gnt0, gnt1, mem_addr} !== {2'b10, 32'h40})
      $display("FAIL rst_tie: got %b %h expected 10 40", {gnt0, gnt1}, mem_addr); else passed++;
    @(negedge clock);
    checks++; if ({done0, rdata} !== {1'b1, mem_model(32'h40)})
      $display("FAIL rst_done0: got %b %h", done0, rdata); else passed++;
    req0 = 0;
    @(negedge clock);
    @(negedge clock);
    checks++; if ({done1, rdata} !== {1'b1, mem_model(32'h44)})
      $display("FAIL rst_done1: got %b %h", done1, rdata); else passed++;
    req1 = 0;
    @(negedge clock);
  endtask

  task automatic test_dropped;
    req0 = 1; we0 = 0; addr0 = 32'h50;
    @(negedge clock);
    req0 = 0;
    @(negedge clock);
    checks++; if ({done0, rdata} !== {1'b1, mem_model(32'h50)})
      $display("FAIL drop_done: got %b %h expected 1 %h", done0, rdata, mem_model(32'h50));
    else passed++;
    @(negedge clock);
    @(negedge clock);
    checks++; if ({gnt0, gnt1, done0} !== 3'b000)
      $display("FAIL drop_idle: got %b expected 000", {gnt0, gnt1, done0}); else passed++;
  endtask

  task automatic test_back_to_back;
    int n0, n1, last_cyc;
    logic [31:0] exp;
    n0 = 0; n1 = 0; last_cyc = -1;
    req0 = 1; we0 = 0; addr0 = 32'h100; q0.push_back(mem_model(addr0));
    req1 = 1; we1 = 0; addr1 = 32'h200; q1.push_back(mem_model(addr1));
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      if ((done0 | done1) && last_cyc >= 0) begin
        checks++; if (cyc - last_cyc != 2)
          $display("FAIL b2b_spacing: got %0d expected 2", cyc - last_cyc); else passed++;
      end
      if (done0 | done1) last_cyc = cyc;
      if (done0) begin
        exp = (q0.size() != 0) ? q0.pop_front() : 'x;
        checks++; if (rdata !== exp) $display("FAIL b2b_rdata0: got %h expected %h", rdata, exp);
        else passed++;
        n0++;
        if (n0 < 4) begin addr0 = 32'h100 + 32'(4 * n0); q0.push_back(mem_model(addr0)); end
        else req0 = 0;
      end
      if (done1) begin
        exp = (q1.size() != 0) ? q1.pop_front() : 'x;
        checks++; if (rdata !== exp) $display("FAIL b2b_rdata1: got %h expected %h", rdata, exp);
        else passed++;
        n1++;
        if (n1 < 4) begin addr1 = 32'h200 + 32'(4 * n1); q1.push_back(mem_model(addr1)); end
        else req1 = 0;
      end
    end
    checks++; if (n0 != 4 || n1 != 4)
      $display("FAIL b2b_count: got %0d/%0d expected 4/4", n0, n1); else passed++;
    q0.delete(); q1.delete();
  endtask

  task automatic test_single_port_rate;
    int n0, last_cyc;
    logic [31:0] exp;
    n0 = 0; last_cyc = -1;
    req0 = 1; we0 = 0; addr0 = 32'h300; q0.push_back(mem_model(addr0));
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clock);
      if (done0) begin
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != 3)
            $display("FAIL rate_spacing: got %0d expected 3", cyc - last_cyc); else passed++;
        end
        last_cyc = cyc;
        exp = (q0.size() != 0) ? q0.pop_front() : 'x;
        checks++; if (rdata !== exp) $display("FAIL rate_rdata: got %h expected %h", rdata, exp);
        else passed++;
        n0++;
        if (n0 < 3) begin addr0 = 32'h300 + 32'(4 * n0); q0.push_back(mem_model(addr0)); end
        else req0 = 0;
      end
    end
    checks++; if (n0 != 3) $display("FAIL rate_count: got %0d expected 3", n0); else passed++;
    q0.delete();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_single_write();
    test_io_protect();
    test_reset_mid();
    test_dropped();
    test_back_to_back();
    test_single_port_rate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
